// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types, sizes and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {StIdle, StGrant} state_e;

    // Requester index -> one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // One-hot grant vector -> requester index (0 for an all-zero vector).
    function automatic logic [SEL_W-1:0] index(logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin mux arbiter.
interface rr_mux_arbiter_if;
    import rr_mux_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   select;
    logic               busy;
    logic               timeout;

    // Requester side.
    modport master (
        output req,
        output done,
        input  gnt,
        input  select,
        input  busy,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output select,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority picker: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick_4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the pointer upward; the 2-bit add wraps 3 -> 0 naturally.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4-input mux among 4 requesters.
// Optional watchdog: define ARB_WATCHDOG_EN to force-release grants held MAX_HOLD cycles.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    rr_mux_arbiter_if.slave   bus
);

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 2");
    end

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;

    logic               found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_rel;

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_pick_4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    // Owner gives the datapath back by finishing or by withdrawing its request.
    assign owner_rel = bus.done[sel_q] | ~bus.req[sel_q];

    // Next-state: grant from IDLE, hold or release in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
`ifdef ARB_WATCHDOG_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
`ifdef ARB_WATCHDOG_EN
                    cnt_d   = '0;
`endif
                end
            end
            StGrant: begin
                if (owner_rel) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = sel_q + 1'b1;
`ifdef ARB_WATCHDOG_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    // Forced release behaves like done but flags the timeout.
                    state_d   = StIdle;
                    gnt_d     = '0;
                    ptr_d     = sel_q + 1'b1;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    // Hold counter and one-cycle timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt    = gnt_q;
    assign bus.select = sel_q;
    assign bus.busy   = (state_q == StGrant);

    sel_matches_gnt: assert property (@(posedge clk) disable iff (reset)
        (state_q == StGrant) |-> ($onehot(gnt_q) && sel_q == index(gnt_q)));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: cycle model of the arbitration rules plus directed checks.
module tb_rr_mux_arbiter;

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned MAX_HOLD = 4;
    localparam bit          WD       = 1'b1;
`else
    localparam int unsigned MAX_HOLD = 16;
    localparam bit          WD       = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Model: owner (-1 = none), rotating pointer, last select, hold length, timeout flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_tmo   = 1'b0;

    always @(posedge clk) begin
        logic [3:0] e_gnt;
        int         c;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && bus.req[c]) begin
                    m_owner = c; m_sel = c; m_hold = 0;
                end
            end
        end else if (bus.done[m_owner] || !bus.req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_hold = 0;
        end else if (WD && m_hold == int'(MAX_HOLD) - 1) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_hold = 0; m_tmo = 1'b1;
        end else begin
            m_hold++;
        end
        #1;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        check("model_gnt", 32'(bus.gnt), 32'(e_gnt));
        check("model_select", 32'(bus.select), 32'(m_sel));
        check("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
        check("model_timeout", 32'(bus.timeout), 32'(m_tmo));
    end

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int held;

    initial begin
        bus.req  = 4'b1111;
        bus.done = 4'b0000;
        repeat (2) step();
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_select", 32'(bus.select), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        step();
        check("first_gnt", 32'(bus.gnt), 32'b0001);
        check("first_select", 32'(bus.select), 32'h0);

        // Round robin 0,1,2,3,0 with a done pulse after 3 cycles and one bubble.
        for (int k = 0; k < 5; k++) begin
            check("rr_gnt", 32'(bus.gnt), 32'(rr_exp[k]));
            if (k == 4) break;
            step(); step();
            bus.done = rr_exp[k];
            step();
            check("rr_bubble", 32'(bus.gnt), 32'h0);
            check("rr_bubble_busy", 32'(bus.busy), 32'h0);
            bus.done = 4'b0000;
            step();
        end

        // Owner 2 withdraws; then ptr=3 wraps to requester 0.
        bus.done = 4'b0001;
        step();
        check("rel0_gnt", 32'(bus.gnt), 32'h0);
        bus.done = 4'b0000;
        bus.req  = 4'b0100;
        step();
        check("own2_gnt", 32'(bus.gnt), 32'b0100);
        check("own2_select", 32'(bus.select), 32'd2);
        bus.req = 4'b0000;
        step();
        check("drop_gnt", 32'(bus.gnt), 32'h0);
        check("drop_select_kept", 32'(bus.select), 32'd2);
        bus.req = 4'b0101;
        step();
        check("wrap_gnt", 32'(bus.gnt), 32'b0001);
        check("wrap_select", 32'(bus.select), 32'd0);

        // Non-owner done and late requests are ignored during a grant.
        bus.done = 4'b0001;
        step();
        bus.done = 4'b0000;
        bus.req  = 4'b0010;
        step();
        check("own1_gnt", 32'(bus.gnt), 32'b0010);
        bus.done = 4'b1000;
        bus.req  = 4'b1111;
        step();
        check("foreign_done_gnt", 32'(bus.gnt), 32'b0010);
        step();
        check("foreign_done_gnt2", 32'(bus.gnt), 32'b0010);

        // Reset mid-grant drops it and clears the pointer.
        bus.done = 4'b0000;
        reset    = 1'b1;
        step();
        check("midreset_gnt", 32'(bus.gnt), 32'h0);
        check("midreset_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        step();
        check("post_reset_gnt", 32'(bus.gnt), 32'b0001);

        // done and req drop together: one release, ptr moves to 1.
        bus.req  = 4'b1110;
        bus.done = 4'b0001;
        step();
        check("dual_rel_gnt", 32'(bus.gnt), 32'h0);
        bus.done = 4'b0000;
        step();
        check("dual_rel_next", 32'(bus.gnt), 32'b0010);

        // Owner 1 holds forever without done.
        bus.req = 4'b1111;
        held    = 1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (bus.gnt == 4'b0010) held++;
            else break;
        end
        if (WD) begin
            check("wd_hold_len", 32'(held), 32'(MAX_HOLD));
            check("wd_timeout", 32'(bus.timeout), 32'h1);
            step();
            check("wd_next_gnt", 32'(bus.gnt), 32'b0100);
            check("wd_timeout_pulse", 32'(bus.timeout), 32'h0);
        end else begin
            check("hold_ge_100", 32'(held >= 100), 32'h1);
            check("no_timeout", 32'(bus.timeout), 32'h0);
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
